// File: rtl/dmem_ctrl.sv
// Data-memory controller: posts stores into a small FIFO write buffer and
// serialises loads behind them on a single request/grant bus.
module dmem_ctrl #(
    parameter int WBUF_DEPTH = 2,
    parameter int AW         = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          memread,
    input  logic                          memwrite,
    input  logic [AW-1:0]                 addr,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          stall,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [AW-1:0]                 bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic                          bus_gnt,
    input  logic                          bus_rvalid,
    input  logic [31:0]                   bus_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wb_level
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [PW:0] DEPTH_L = WBUF_DEPTH[PW:0];

    typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

    state_t        r_state;
    logic [AW-3:0] r_waddr [WBUF_DEPTH];
    logic [31:0]   r_wdata [WBUF_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_rdata;

    logic w_full, w_empty, w_rd, w_enq, w_deq, w_wr_present, w_last;
    logic w_unused;

    assign w_unused = ^addr[1:0];
    assign w_full   = (r_count == DEPTH_L);
    assign w_empty  = (r_count == '0);
    // A combined read+write request is a store; the read half is dropped.
    assign w_rd     = memread & ~memwrite;
    assign w_enq    = memwrite & ~w_full;

    // Buffered stores only go out while no load owns the bus.
    assign w_wr_present = ((r_state == IDLE) || (r_state == DRAIN)) && !w_empty;
    assign w_deq        = w_wr_present & bus_gnt;
    assign w_last       = w_deq && (r_count == {{PW{1'b0}}, 1'b1}) && !w_enq;

    assign bus_req   = w_wr_present || (r_state == RD_REQ);
    assign bus_we    = w_wr_present;
    assign bus_addr  = w_wr_present          ? {r_waddr[r_rptr], 2'b00} :
                       (r_state == RD_REQ)   ? {addr[AW-1:2], 2'b00}    : '0;
    assign bus_wdata = w_wr_present ? r_wdata[r_rptr] : '0;

    assign stall    = (memwrite & w_full) | (w_rd & (r_state != RD_DONE));
    assign readdata = r_rdata;
    assign wb_level = r_count;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_waddr[r_wptr] <= addr[AW-1:2];
            r_wdata[r_wptr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_rd) r_state <= w_empty ? RD_REQ : DRAIN;
                // Empty on entry is possible when the last store was granted in IDLE.
                DRAIN:   if (w_empty || w_last) r_state <= RD_REQ;
                RD_REQ:  if (bus_gnt) r_state <= RD_WAIT;
                RD_WAIT: if (bus_rvalid) begin
                             r_rdata <= bus_rdata;
                             r_state <= RD_DONE;
                         end
                RD_DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected bus transfers are queued as
// stimulus is driven and retired by a bus monitor when granted.
module tb_dmem_ctrl;

    localparam int AW = 32;
    localparam int WBUF_DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          memread = 1'b0;
    logic          memwrite = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          stall;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_gnt = 1'b0;
    logic          bus_rvalid = 1'b0;
    logic [31:0]   bus_rdata = '0;
    logic [$clog2(WBUF_DEPTH):0] wb_level;

    int errors = 0;
    int checks = 0;

    logic [AW+31:0] wq[$];
    logic [AW-1:0]  rq[$];
    logic [AW+31:0] m_w;
    logic [AW-1:0]  m_r;

    dmem_ctrl #(.WBUF_DEPTH(WBUF_DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .wb_level(wb_level)
    );

    always #5 clk = ~clk;

    // Bus monitor: every accepted transfer must match the head of its queue.
    always @(negedge clk) begin
        if (reset && bus_req && bus_gnt) begin
            checks++;
            if (bus_we) begin
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL bus_write: unexpected write addr=%h data=%h", bus_addr, bus_wdata);
                end else begin
                    m_w = wq.pop_front();
                    if ({bus_addr, bus_wdata} !== m_w) begin
                        errors++;
                        $display("FAIL bus_write: got %h/%h expected %h/%h",
                                 bus_addr, bus_wdata, m_w[AW+31:32], m_w[31:0]);
                    end
                end
            end else begin
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL bus_read: unexpected read addr=%h", bus_addr);
                end else begin
                    m_r = rq.pop_front();
                    if (bus_addr !== m_r) begin
                        errors++;
                        $display("FAIL bus_read: got addr %h expected %h", bus_addr, m_r);
                    end
                end
                checks++;
                if (wq.size() != 0 || wb_level !== '0) begin
                    errors++;
                    $display("FAIL read_order: read issued with %0d stores pending, wb_level=%0d",
                             wq.size(), wb_level);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, bus_req, bus_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/req/we=%b expected 000", {stall, bus_req, bus_we});
        end
        checks++;
        if ({bus_addr, bus_wdata, readdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", bus_addr, bus_wdata, readdata);
        end
        checks++;
        if (wb_level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d expected 0", wb_level);
        end
        tick;
        reset = 1'b1;
    endtask

    task automatic test_store;
        tick;
        bus_gnt = 1'b1;
        memwrite = 1'b1; addr = 32'h104; writedata = 32'hDEADBEEF;
        wq.push_back({32'h104, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || wb_level !== 0) begin
            errors++;
            $display("FAIL store_accept: got stall=%b level=%0d expected 0/0", stall, wb_level);
        end
        tick;
        memwrite = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we} !== 2'b11 || wb_level !== 1) begin
            errors++;
            $display("FAIL store_issue: got req/we=%b level=%0d expected 11/1", {bus_req, bus_we}, wb_level);
        end
        tick;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || wb_level !== 0) begin
            errors++;
            $display("FAIL store_done: got req=%b level=%0d expected 0/0", bus_req, wb_level);
        end
    endtask

    task automatic test_backpressure;
        tick;
        bus_gnt = 1'b0;
        memwrite = 1'b1; addr = 32'h10; writedata = 32'hA0A0A0A0;
        wq.push_back({32'h10, 32'hA0A0A0A0});
        tick;
        addr = 32'h14; writedata = 32'hB1B1B1B1;
        wq.push_back({32'h14, 32'hB1B1B1B1});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || wb_level !== 1) begin
            errors++;
            $display("FAIL bp_second: got stall=%b level=%0d expected 0/1", stall, wb_level);
        end
        tick;
        addr = 32'h18; writedata = 32'hC2C2C2C2;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || wb_level !== 2) begin
            errors++;
            $display("FAIL bp_full: got stall=%b level=%0d expected 1/2", stall, wb_level);
        end
        tick;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bus_addr !== 32'h10) begin
            errors++;
            $display("FAIL bp_hold: got stall=%b addr=%h expected 1/00000010", stall, bus_addr);
        end
        tick;
        bus_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_same_cycle: got stall=%b expected 1", stall);
        end
        wq.push_back({32'h18, 32'hC2C2C2C2});
        tick;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || wb_level !== 1) begin
            errors++;
            $display("FAIL bp_after_release: got stall=%b level=%0d expected 0/1", stall, wb_level);
        end
        tick;
        memwrite = 1'b0;
        tick;
        @(negedge clk);
        checks++;
        if (wb_level !== 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL bp_drained: got level=%0d pending=%0d expected 0/0", wb_level, wq.size());
        end
    endtask

    // Drives a load from the current cycle; rvalid follows one cycle after grant.
    task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d, input int exp_n, input string nm);
        int  n = 0;
        bit  done = 0;
        bit  acc;
        memread = 1'b1; addr = a;
        rq.push_back({a[AW-1:2], 2'b00});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall) begin done = 1; break; end
            n++;
            acc = bus_req & ~bus_we & bus_gnt;
            tick;
            bus_rvalid = acc;
            bus_rdata  = acc ? d : $urandom;
        end
        bus_rvalid = 1'b0;
        checks++;
        if (!done || readdata !== d) begin
            errors++;
            $display("FAIL %s_data: got done=%0d readdata=%h expected %h", nm, done, readdata, d);
        end
        if (exp_n >= 0) begin
            checks++;
            if (n != exp_n) begin
                errors++;
                $display("FAIL %s_stall_cycles: got %0d expected %0d", nm, n, exp_n);
            end
        end
        tick;
        memread = 1'b0;
        @(negedge clk);
        checks++;
        if (readdata !== d || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got readdata=%h stall=%b expected %h/0", nm, readdata, stall, d);
        end
    endtask

    task automatic test_load;
        tick;
        bus_gnt = 1'b1;
        do_load(32'h203, 32'h12345678, 3, "load");
    endtask

    task automatic test_store_then_load;
        tick;
        bus_gnt = 1'b1;
        memwrite = 1'b1; addr = 32'h40; writedata = 32'h55AA0040;
        wq.push_back({32'h40, 32'h55AA0040});
        tick;
        memwrite = 1'b0;
        do_load(32'h40, 32'h0F0F4040, 4, "st_ld");
    endtask

    task automatic test_reset_mid;
        tick;
        bus_gnt = 1'b1;
        memread = 1'b1; addr = 32'h300;
        rq.push_back(32'h300);
        tick;
        tick;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: got stall=%b req=%b expected 1/0", stall, bus_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (readdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got readdata=%h expected 0", readdata);
        end
        tick;
        reset = 1'b1;
        memread = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick;
        bus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (readdata !== '0 || stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_rvalid: got readdata=%h stall=%b req=%b expected 0/0/0",
                     readdata, stall, bus_req);
        end
        tick;
        do_load(32'h3A4, 32'h0BADF00D, 3, "post_rst");
    endtask

    task automatic test_rw_both;
        tick;
        bus_gnt = 1'b1;
        memread = 1'b1; memwrite = 1'b1; addr = 32'h80; writedata = 32'h80808080;
        wq.push_back({32'h80, 32'h80808080});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rw_stall: got %b expected 0", stall);
        end
        tick;
        memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we} !== 2'b11) begin
            errors++;
            $display("FAIL rw_write: got req/we=%b expected 11", {bus_req, bus_we});
        end
        tick;
        tick;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL rw_done: got req=%b wq=%0d rq=%0d expected 0/0/0", bus_req, wq.size(), rq.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            ok;
        for (int i = 0; i < 16; i++) begin
            tick;
            bus_gnt = 1'($urandom_range(0, 1));
            a = 32'h1000 + 32'(i * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            memwrite = 1'b1; addr = a; writedata = d;
            ok = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (!stall) begin ok = 1; break; end
                tick;
                bus_gnt = 1'($urandom_range(0, 1));
            end
            if (ok) wq.push_back({a[AW-1:2], 2'b00, d});
            else begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout: store %0d stalled beyond 50 cycles", i);
            end
        end
        tick;
        memwrite = 1'b0;
        bus_gnt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wb_level == 0) break;
            tick;
        end
        checks++;
        if (wb_level !== 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got level=%0d pending=%0d expected 0/0", wb_level, wq.size());
        end
    endtask

    initial begin
        test_reset;
        test_store;
        test_backpressure;
        test_load;
        test_store_then_load;
        test_reset_mid;
        test_rw_both;
        test_back_to_back;
        tick;
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL final_queues: got wq=%0d rq=%0d expected 0/0", wq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, posted-write buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter AW, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port memread  input  1  core load request.
REQ-006 SHALL have port memwrite  input  1  core store request.
REQ-007 SHALL have port addr  input  AW  core byte address (ALU result).
REQ-008 SHALL have port writedata  input  32  core store data.
REQ-009 SHALL have port readdata  output  32  load data to core.
REQ-010 SHALL have port stall  output  1  core must hold PC and inputs while high.
REQ-011 SHALL have port bus_req  output  1  bus request.
REQ-012 SHALL have port bus_we  output  1  1 = write transfer.
REQ-013 SHALL have port bus_addr  output  AW  word-aligned bus address.
REQ-014 SHALL have port bus_wdata  output  32  bus write data.
REQ-015 SHALL have port bus_gnt  input  1  transfer accepted when bus_req & bus_gnt.
REQ-016 SHALL have port bus_rvalid  input  1  read data valid.
REQ-017 SHALL have port bus_rdata  input  32  read data.
REQ-018 SHALL have port wb_level  output  $clog2(WBUF_DEPTH)+1  write-buffer occupancy.

Function
REQ-019 SHALL force bus_addr[1:0] = 0; addr[1:0] ignored.
REQ-020 SHALL treat memread & memwrite both high as a write; read ignored.
REQ-021 SHALL enqueue {addr, writedata} into the FIFO write buffer on any cycle with memwrite high and buffer not full at cycle start.
REQ-022 SHALL drive stall = (memwrite & full) | (memread & state != RD_DONE), combinationally.
REQ-023 SHALL use full as registered occupancy == WBUF_DEPTH; simultaneous dequeue does not clear stall that cycle.
REQ-024 SHALL implement FSM states IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE.
REQ-025 IDLE: memread & buffer empty -> RD_REQ; memread & non-empty -> DRAIN; else stay.
REQ-026 DRAIN: stay until the last buffered write is granted, then -> RD_REQ.
REQ-027 RD_REQ: bus_req=1, bus_we=0, bus_addr=aligned addr; on bus_gnt -> RD_WAIT.
REQ-028 RD_WAIT: bus_req=0; on bus_rvalid capture bus_rdata into rdata_q, -> RD_DONE.
REQ-029 RD_DONE: stall low for exactly one cycle, readdata=rdata_q; -> IDLE unconditionally.
REQ-030 SHALL present buffer head as bus_req=1, bus_we=1 in IDLE and DRAIN whenever buffer non-empty; dequeue on bus_gnt.
REQ-031 SHALL hold bus_addr, bus_we, bus_wdata stable while bus_req high and bus_gnt low.
REQ-032 SHALL issue no write in RD_REQ/RD_WAIT/RD_DONE; loads never bypass buffered stores.
REQ-033 SHALL ignore bus_rvalid outside RD_WAIT.
REQ-034 Minimum load stall with empty buffer, gnt in RD_REQ, rvalid next cycle: 3 cycles (IDLE, RD_REQ, RD_WAIT).
REQ-035 SHALL handle enqueue and dequeue in the same cycle with occupancy unchanged and FIFO order kept.
REQ-036 readdata SHALL hold rdata_q at all times outside reset.

Reset
REQ-037 On reset low: state=IDLE, buffer emptied, wb_level=0, rdata_q=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; stall follows REQ-022 with these values.
REQ-038 Reset mid-transaction SHALL abandon it; a late bus_rvalid after reset release SHALL be ignored.

Verification
REQ-039 Store to 0x104, data 0xDEADBEEF, gnt tied 1 -> stall 0; next cycle bus_req=1, bus_we=1, bus_addr=0x104, bus_wdata=0xDEADBEEF; wb_level 1 then 0.
REQ-040 Three back-to-back stores, gnt held 0, WBUF_DEPTH=2 -> third store stall=1, wb_level=2; release gnt -> stall drops, writes leave in order.
REQ-041 Load 0x203, buffer empty, gnt immediate, rvalid 1 cycle later with 0x12345678 -> bus_addr=0x200, stall high 3 cycles, RD_DONE readdata=0x12345678.
REQ-042 Store 0x40 then load 0x40 -> write granted before read request; read bus_req only after wb_level=0.
REQ-043 Assert reset in RD_WAIT, then rvalid after release -> state IDLE, readdata=0, no capture.
REQ-044 memread=memwrite=1 at 0x80 -> single write transfer, no read request, stall 0.
